// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command scheduler: FSM encoding, command limit and
// the error codes placed in the upper byte of a response frame.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StWaitRsp,
        StTxLoad,
        StTxWait
    } state_e;

    localparam logic [7:0] CMD_MAX     = 8'h07;
    localparam logic [7:0] ERR_ADDR    = 8'hE0;
    localparam logic [7:0] ERR_CMD     = 8'hE1;
    localparam logic [7:0] ERR_TIMEOUT = 8'hE2;

    function automatic logic [15:0] err_frame(input logic [7:0] code, input logic [7:0] addr);
        return {code, addr};
    endfunction

endpackage

// File: rtl/cmd_buf1.sv
// One-entry 16-bit holding register for a frame that arrives while the scheduler is busy.
// A simultaneous read and write leaves the buffer full with the newly written frame.
module cmd_buf1 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic [15:0] wr_data,
    input  logic        rd,
    output logic        full,
    output logic [15:0] rd_data
);

    logic        full_q, full_d;
    logic [15:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (rd) begin
            full_d = 1'b0;
        end
        if (wr) begin
            full_d = 1'b1;
            data_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full    = full_q;
    assign rd_data = data_q;

endmodule

// File: rtl/uart_cmd_sched.sv
// Routes received command frames to an addressed device, waits for its response or a
// timeout, and hands the resulting frame to the transmitter.
module uart_cmd_sched
    import uart_cmd_pkg::*;
#(
    parameter int unsigned NUM_DEV     = 4,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        rx_data,
    input  logic               rx_valid,
    output logic [NUM_DEV-1:0] dev_req,
    output logic [7:0]         dev_cmd,
    input  logic [NUM_DEV-1:0] dev_rsp_valid,
    input  logic [15:0]        dev_rsp_data,
    output logic [15:0]        tx_data,
    output logic               tx_start,
    input  logic               tx_done,
    output logic               busy,
    output logic               overrun
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned SelW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] NumDevB = 8'(NUM_DEV);

    state_e              state_q, state_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          addr_q, addr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [15:0]         rsp_q, rsp_d;
    logic [NUM_DEV-1:0]  dev_req_q, dev_req_d;
    logic [7:0]          dev_cmd_q, dev_cmd_d;
    logic [15:0]         tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;

    logic                buf_wr, buf_rd, buf_full;
    logic [15:0]         buf_data;
    logic [SelW-1:0]     sel;

    assign sel = addr_q[SelW-1:0];

    cmd_buf1 u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (buf_wr),
        .wr_data (rx_data),
        .rd      (buf_rd),
        .full    (buf_full),
        .rd_data (buf_data)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rsp_d      = rsp_q;
        dev_req_d  = dev_req_q;
        dev_cmd_d  = dev_cmd_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = 1'b0;
        buf_wr     = 1'b0;
        buf_rd     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A buffered frame is older than anything arriving now, so serve it first.
                if (buf_full) begin
                    {cmd_d, addr_d} = buf_data;
                    buf_rd          = 1'b1;
                    buf_wr          = rx_valid;
                    state_d         = StDecode;
                end else if (rx_valid) begin
                    {cmd_d, addr_d} = rx_data;
                    state_d         = StDecode;
                end
            end
            StDecode: begin
                if (addr_q >= NumDevB) begin
                    rsp_d   = err_frame(ERR_ADDR, addr_q);
                    state_d = StTxLoad;
                end else if (cmd_q > CMD_MAX) begin
                    rsp_d   = err_frame(ERR_CMD, addr_q);
                    state_d = StTxLoad;
                end else begin
                    cnt_d     = '0;
                    dev_cmd_d = cmd_q;
                    for (int i = 0; i < int'(NUM_DEV); i++) begin
                        dev_req_d[i] = (addr_q == 8'(i));
                    end
                    state_d   = StWaitRsp;
                end
            end
            StWaitRsp: begin
                cnt_d = cnt_q + CntW'(1);
                if (dev_rsp_valid[sel]) begin
                    rsp_d     = dev_rsp_data;
                    dev_req_d = '0;
                    state_d   = StTxLoad;
                end else if (cnt_q == CntLast) begin
                    rsp_d     = err_frame(ERR_TIMEOUT, addr_q);
                    dev_req_d = '0;
                    state_d   = StTxLoad;
                end
            end
            StTxLoad: begin
                tx_data_d  = rsp_q;
                tx_start_d = 1'b1;
                state_d    = StTxWait;
            end
            StTxWait: begin
                if (tx_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && rx_valid) begin
            if (buf_full) begin
                overrun_d = 1'b1;
            end else begin
                buf_wr = 1'b1;
            end
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            rsp_q      <= '0;
            dev_req_q  <= '0;
            dev_cmd_q  <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rsp_q      <= rsp_d;
            dev_req_q  <= dev_req_d;
            dev_cmd_q  <= dev_cmd_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign dev_req  = dev_req_q;
    assign dev_cmd  = dev_cmd_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule
